// File: rtl/kamikaze_imem_arbiter.sv
// Arbiter that shares one single-port instruction memory between fetch and load/store.
// Fetch takes priority only after STARVE_LIMIT consecutive LSU wins while it was waiting.
module kamikaze_imem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic [31:0] if_data_o,
    output logic        if_rvalid_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_be_i,
    output logic        ls_gnt_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_rvalid_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } own_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    own_e       own_q, own_d;
    logic [3:0] starve_q, starve_d;
    logic       if_gnt, ls_gnt;

    // Grants are gated by reset so nothing reaches the port while rst_i is low.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (rst_i) begin
            if (if_req_i && ls_req_i) begin
                if (starve_q == LIMIT) begin
                    if_gnt = 1'b1;
                end else begin
                    ls_gnt = 1'b1;
                end
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end else if (ls_req_i) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (if_gnt) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i & WORD_MASK;
            mem_be_o   = 4'hF;
        end else if (ls_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i & WORD_MASK;
            mem_be_o    = ls_we_i ? ls_be_i : 4'hF;
            mem_wdata_o = ls_wdata_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        own_d    = OWN_NONE;
        if (!if_req_i || if_gnt) begin
            starve_d = 4'd0;
        end else if (ls_gnt && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
        if (if_gnt) begin
            own_d = OWN_IF;
        end else if (ls_gnt && !ls_we_i) begin
            own_d = OWN_LS;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            own_q    <= OWN_NONE;
            starve_q <= 4'd0;
        end else begin
            own_q    <= own_d;
            starve_q <= starve_d;
        end
    end

    // Read data is steered straight from the port to whichever requester owns the response.
    always_comb begin
        if_gnt_o    = if_gnt;
        ls_gnt_o    = ls_gnt;
        if_rvalid_o = (own_q == OWN_IF);
        ls_rvalid_o = (own_q == OWN_LS);
        if_data_o   = (own_q == OWN_IF) ? mem_rdata_i : 32'h0;
        ls_rdata_o  = (own_q == OWN_LS) ? mem_rdata_i : 32'h0;
    end

endmodule
